sample_framer: RTL and testbench

- Assembles per-channel ADC samples, arriving serially one channel per strobe, into one wide frame of NUM_CHANNELS x BITS_PER_SAMPLE.
- Emits each frame as a one-cycle push toward the sample FIFO.
- Raises a resync pulse every FRAMES_PER_BLOCK frames for the SPI chip-select framing.
- Provides a selectable ramp test-pattern mode and a saturating framing-error counter; sits between the ADC front end and the sample FIFO.

---
 rtl/sample_pkg.sv | 19 +
 rtl/sample_framer_block_counter.sv | 35 +++
 rtl/sample_framer.sv | 136 +++++++++++++
 tb/tb_sample_framer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared sizing, mode and state encodings for the ADC sample framer.
// Lanes are packed so lane i lands at bits [BITS*i +: BITS] of a frame.
package sample_pkg;

   localparam int NUM_CHANNELS    = 8;
   localparam int BITS_PER_SAMPLE = 16;
   localparam int SAMPLE_WIDTH    = NUM_CHANNELS * BITS_PER_SAMPLE;

   localparam logic MODE_LIVE = 1'b0;
   localparam logic MODE_RAMP = 1'b1;

   typedef enum logic {
      SYNC    = 1'b0,
      COLLECT = 1'b1
   } state_e;

   typedef logic [NUM_CHANNELS-1:0][BITS_PER_SAMPLE-1:0] lanes_t;

endpackage

// File: rtl/sample_framer_block_counter.sv
// Wrap counter 0..WRAP-1 with a terminal-count flag on the last value.
// Generic enough to double as a slow blink divider.
module block_counter #(
   parameter int WRAP = 48,
   parameter int CW   = (WRAP > 1) ? $clog2(WRAP) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CW-1:0] count_q, count_d;

   assign tc = (count_q == CW'(WRAP - 1));

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = tc ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sample_framer.sv
// Packs serial per-channel ADC samples (or a ramp pattern) into wide
// frames, with block resync pulses and a saturating framing-error count.
module sample_framer
   import sample_pkg::*;
#(
   parameter int FRAMES_PER_BLOCK = 48,
   parameter int RAMP_STEP        = 2,
   parameter int ERR_WIDTH        = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mode,
   input  logic [BITS_PER_SAMPLE-1:0] ch_data,
   input  logic                       ch_valid,
   input  logic                       ch_first,
   input  logic                       sample_tick,
   output logic [SAMPLE_WIDTH-1:0]    frame_data,
   output logic                       frame_valid,
   output logic                       resync,
   output logic [ERR_WIDTH-1:0]       err_count
);

   localparam int IW = $clog2(NUM_CHANNELS);

   state_e               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   lanes_t               lane_q, lane_d;
   lanes_t               frame_q, frame_d;
   logic                 valid_q, valid_d;
   logic                 resync_q, resync_d;
   logic [ERR_WIDTH-1:0] err_q, err_d;
   logic                 mode_q;

   logic mode_chg;
   logic push;
   logic err_inc;
   logic blk_tc;

   assign mode_chg = (mode != mode_q);

   block_counter #(
      .WRAP (FRAMES_PER_BLOCK)
   ) u_blk (
      .clk (clk),
      .rst (rst),
      .clr (mode_chg),
      .en  (push),
      .tc  (blk_tc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      push    = 1'b0;
      err_inc = 1'b0;
      if (mode_chg) begin
         // Mode switch wins over any same-cycle sample or tick.
         state_d = SYNC;
         idx_d   = '0;
         lane_d  = '0;
      end else if (mode_q == MODE_RAMP) begin
         if (sample_tick) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
               lane_d[i] = lane_q[i]
                         + BITS_PER_SAMPLE'(RAMP_STEP * i);
            end
            push = 1'b1;
         end
      end else if (mode_q == MODE_LIVE && ch_valid) begin
         unique case (state_q)
            SYNC: begin
               if (ch_first) begin
                  lane_d[0] = ch_data;
                  idx_d     = IW'(1);
                  state_d   = COLLECT;
               end else begin
                  err_inc = 1'b1;
               end
            end
            COLLECT: begin
               if (ch_first) begin
                  err_inc   = (idx_q != '0);
                  lane_d[0] = ch_data;
                  idx_d     = IW'(1);
               end else if (idx_q == '0) begin
                  err_inc = 1'b1;
                  state_d = SYNC;
               end else begin
                  lane_d[idx_q] = ch_data;
                  if (idx_q == IW'(NUM_CHANNELS - 1)) begin
                     idx_d = '0;
                     push  = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
            default: state_d = SYNC;
         endcase
      end
      frame_d  = push ? lane_d : frame_q;
      valid_d  = push;
      resync_d = push & blk_tc;
      err_d    = (err_inc && err_q != '1)
               ? err_q + ERR_WIDTH'(1) : err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= SYNC;
         idx_q    <= '0;
         lane_q   <= '0;
         frame_q  <= '0;
         valid_q  <= 1'b0;
         resync_q <= 1'b0;
         err_q    <= '0;
         mode_q   <= MODE_LIVE;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lane_q   <= lane_d;
         frame_q  <= frame_d;
         valid_q  <= valid_d;
         resync_q <= resync_d;
         err_q    <= err_d;
         mode_q   <= mode;
      end
   end

   assign frame_data  = frame_q;
   assign frame_valid = valid_q;
   assign resync      = resync_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_sample_framer.sv
// Self-checking bench for sample_framer: directed table, corner
// sequences and random traffic against a queue-based frame model.
module tb_sample_framer;

   localparam int NCH  = 8;
   localparam int BW   = 16;
   localparam int FPB  = 48;
   localparam int STEP = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           mode;
   logic [BW-1:0]  ch_data;
   logic           ch_valid;
   logic           ch_first;
   logic           sample_tick;
   logic [127:0]   frame_data;
   logic           frame_valid;
   logic           resync;
   logic [7:0]     err_count;

   sample_framer #(
      .FRAMES_PER_BLOCK (FPB),
      .RAMP_STEP        (STEP),
      .ERR_WIDTH        (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .ch_data     (ch_data),
      .ch_valid    (ch_valid),
      .ch_first    (ch_first),
      .sample_tick (sample_tick),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .resync      (resync),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   function automatic void chk(string nm, logic [127:0] act,
                               logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Reference model: frames built from a queue of collected samples
   typedef struct {
      logic [127:0] f;
      bit           rs;
      int           c;
   } exp_t;

   exp_t         exq[$];
   logic [BW-1:0] part[$];
   bit           synced;
   bit           mode_m;
   int           err_m;
   int           nfr_m;
   int           ramp_k;
   logic [127:0] hold_ref;

   function automatic void err_inc();
      if (err_m < 255) err_m++;
   endfunction

   function automatic void push_exp(logic [127:0] fr, int c);
      exp_t e;
      nfr_m++;
      e.f  = fr;
      e.rs = (nfr_m % FPB) == 0;
      e.c  = c;
      exq.push_back(e);
   endfunction

   function automatic void model_clear();
      part.delete();
      synced = 1'b0;
      nfr_m  = 0;
      ramp_k = 0;
   endfunction

   function automatic void live_sample(logic [BW-1:0] d, bit f, int c);
      logic [127:0] fr;
      if (!synced) begin
         if (f) begin
            part.delete();
            part.push_back(d);
            synced = 1'b1;
         end else begin
            err_inc();
         end
      end else if (f) begin
         if (part.size() != 0) err_inc();
         part.delete();
         part.push_back(d);
      end else if (part.size() == 0) begin
         err_inc();
         synced = 1'b0;
      end else begin
         part.push_back(d);
         if (part.size() == NCH) begin
            for (int i = 0; i < NCH; i++) fr[i*BW +: BW] = part[i];
            push_exp(fr, c);
            part.delete();
         end
      end
   endfunction

   task automatic apply(bit v, bit f, logic [BW-1:0] d, bit t);
      logic [127:0] fr;
      ch_valid    = v;
      ch_first    = f;
      ch_data     = d;
      sample_tick = t;
      if (mode_m == 1'b0) begin
         if (v) live_sample(d, f, cyc + 1);
      end else if (t) begin
         ramp_k++;
         for (int i = 0; i < NCH; i++)
            fr[i*BW +: BW] = BW'(ramp_k * STEP * i);
         push_exp(fr, cyc + 1);
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         apply(1'b0, 1'b0, '0, 1'b0);
      end
   endtask

   task automatic send_frame(logic [BW-1:0] base);
      for (int i = 0; i < NCH; i++) begin
         @(negedge clk);
         apply(1'b1, i == 0, base + BW'(i), 1'b0);
      end
   endtask

   task automatic set_mode(bit m);
      @(negedge clk);
      mode = m;
      apply(1'b0, 1'b0, '0, 1'b0);
      mode_m = m;
      model_clear();
      idle(3);
   endtask

   task automatic do_reset();
      idle(2);
      chk("pending_before_reset", exq.size(), 0);
      @(negedge clk);
      rst  = 1'b1;
      mode = 1'b0;
      apply(1'b0, 1'b0, '0, 1'b0);
      exq.delete();
      model_clear();
      mode_m   = 1'b0;
      err_m    = 0;
      hold_ref = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Output monitor / scoreboard
   int           mon_frames = 0;
   int           rs_idx[$];
   logic [127:0] last_frame;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_valid) begin
            mon_frames++;
            if (resync) rs_idx.push_back(mon_frames);
            last_frame = frame_data;
            chk("frame_expected", exq.size() != 0, 1);
            if (exq.size() != 0) begin
               exp_t e;
               e = exq.pop_front();
               chk("frame_data", frame_data, e.f);
               chk("frame_cycle", cyc, e.c);
               chk("resync", resync, e.rs);
               hold_ref = e.f;
            end
         end else begin
            chk("frame_hold", frame_data, hold_ref);
            chk("resync_idle", resync, 0);
         end
      end
   end

   typedef struct {
      logic [BW-1:0] d;
      bit            f;
      bit            ep;
      int            ee;
   } vec_t;

   vec_t tv[29];

   initial begin
      bit v, f;
      for (int i = 0; i < 29; i++) begin
         tv[i].ep = 1'b0;
         if (i < 8) begin
            tv[i].d = BW'(32'h1000 + i);
            tv[i].f = (i == 0);
            tv[i].ep = (i == 7);
            tv[i].ee = 0;
         end else if (i < 11) begin
            tv[i].d = BW'(32'h2000 + i - 8);
            tv[i].f = (i == 8);
            tv[i].ee = 0;
         end else if (i < 19) begin
            tv[i].d = BW'(32'h3000 + i - 11);
            tv[i].f = (i == 11);
            tv[i].ep = (i == 18);
            tv[i].ee = 1;
         end else if (i < 21) begin
            tv[i].d = (i == 19) ? 16'h4444 : 16'h5555;
            tv[i].f = 1'b0;
            tv[i].ee = i - 17;
         end else begin
            tv[i].d = BW'(32'h6000 + i - 21);
            tv[i].f = (i == 21);
            tv[i].ep = (i == 28);
            tv[i].ee = 3;
         end
      end

      rst = 1'b1;
      mode = 1'b0;
      ch_valid = 1'b0;
      ch_first = 1'b0;
      ch_data = '0;
      sample_tick = 1'b0;
      mode_m = 1'b0;
      err_m = 0;
      hold_ref = '0;
      model_clear();
      repeat (2) @(negedge clk);
      chk("rst_frame_data", frame_data, 0);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_resync", resync, 0);
      chk("rst_err", err_count, 0);
      rst = 1'b0;

      // Clean frame, partial-frame misalignment, stray samples
      for (int k = 0; k <= 29; k++) begin
         @(negedge clk);
         if (k > 0) begin
            chk("tbl_valid", frame_valid, tv[k-1].ep);
            chk("tbl_err", err_count, tv[k-1].ee);
         end
         if (k < 29) apply(1'b1, tv[k].f, tv[k].d, 1'b0);
         else        apply(1'b0, 1'b0, '0, 1'b0);
      end
      idle(2);
      chk("tbl_model_err", err_count, err_m);

      // 96 clean frames: resync on frames 48 and 96
      do_reset();
      @(posedge clk);
      mon_frames = 0;
      rs_idx.delete();
      for (int n = 0; n < 96; n++) send_frame(BW'($urandom));
      idle(3);
      chk("rs96_count", rs_idx.size(), 2);
      chk("rs96_first", rs_idx.size() > 0 ? rs_idx[0] : -1, 48);
      chk("rs96_second", rs_idx.size() > 1 ? rs_idx[1] : -1, 96);

      // Ramp: ch_* activity is ignored
      set_mode(1'b1);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         apply(1'b1, $urandom_range(0, 1) == 1, BW'($urandom), 1'b1);
         @(negedge clk);
         apply(1'b1, $urandom_range(0, 1) == 1, BW'($urandom), 1'b0);
      end
      idle(2);
      chk("ramp_lane7", last_frame[7*BW +: BW], 42);
      chk("ramp_lane1", last_frame[1*BW +: BW], 6);
      for (int n = 0; n < 7; n++) begin
         @(negedge clk);
         apply(1'b0, 1'b0, '0, 1'b1);
      end
      idle(2);
      chk("ramp10_lane3", last_frame[3*BW +: BW], 60);

      // Ramp -> live after 10 frames: counter restarts, no error
      set_mode(1'b0);
      @(posedge clk);
      mon_frames = 0;
      rs_idx.delete();
      for (int n = 0; n < 48; n++) send_frame(BW'($urandom));
      idle(3);
      chk("switch_rs_count", rs_idx.size(), 1);
      chk("switch_rs_at", rs_idx.size() > 0 ? rs_idx[0] : -1, 48);
      chk("switch_err", err_count, 0);

      // Random traffic with mode switches
      for (int ch = 0; ch < 6; ch++) begin
         bit m;
         m = $urandom_range(0, 1) == 1;
         if (m != mode_m) set_mode(m);
         repeat (200) begin
            @(negedge clk);
            v = $urandom_range(0, 9) < 7;
            f = ($urandom_range(0, 9) == 0) ||
                (part.size() == 0 && $urandom_range(0, 3) != 0);
            apply(v, f, BW'($urandom), $urandom_range(0, 3) == 0);
         end
         idle(2);
         chk("rand_err", err_count, err_m);
      end

      // Saturation of the error counter
      do_reset();
      send_frame(16'hA500);
      repeat (300) begin
         @(negedge clk);
         apply(1'b1, 1'b0, BW'($urandom), 1'b0);
      end
      idle(2);
      chk("sat_err", err_count, 255);
      chk("sat_model", err_count, err_m);
      repeat (5) begin
         @(negedge clk);
         apply(1'b1, 1'b0, BW'($urandom), 1'b0);
      end
      idle(2);
      chk("sat_hold", err_count, 255);

      // Asynchronous reset in the middle of a frame
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         apply(1'b1, i == 0, BW'(16'h7700 + i), 1'b0);
      end
      @(negedge clk);
      apply(1'b0, 1'b0, '0, 1'b0);
      chk("pre_arst_pending", exq.size(), 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_frame_data", frame_data, 0);
      chk("arst_frame_valid", frame_valid, 0);
      chk("arst_resync", resync, 0);
      chk("arst_err", err_count, 0);
      exq.delete();
      model_clear();
      err_m = 0;
      hold_ref = '0;
      @(negedge clk);
      rst = 1'b0;
      send_frame(16'h0B00);
      idle(3);
      chk("post_arst_err", err_count, 0);
      chk("pending_end", exq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
